// File: rtl/key_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_cond_pkg
//  Description : Shared definitions for the key conditioner: per-key FSM
//                state encoding, default timing parameters and counter width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package key_cond_pkg;

  // Every counter in the block shares this width.
  localparam int unsigned C_CNT_W = 25;

  // Default timings are given in cycles of a 50 MHz clock.
  localparam int unsigned C_DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
  localparam int unsigned C_DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
  localparam int unsigned C_DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms

  typedef logic [C_CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } key_state_e;

endpackage : key_cond_pkg
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// ============================================================================
//  Module      : key_channel
//  Description : Conditioning for one push button: 2-flop synchronizer,
//                debounce FSM, auto-repeat counter and registered pulses.
//  Ports       : clk_i        - system clock
//                rst_ni       - asynchronous active-low reset
//                key_ni       - raw button, active-low, asynchronous
//                repeat_en_i  - enables the auto-repeat pulse output
//                level_o      - debounced level, high while pressed
//                press_o      - one-cycle pulse on accepted press
//                release_o    - one-cycle pulse on accepted release
//                repeat_o     - one-cycle auto-repeat pulse while held
//  Revision    : 1.0 - initial release
// ============================================================================
module key_channel
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = C_DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = C_DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = C_DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam cnt_t C_DEB_LAST   = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t C_RPT_DELAY  = cnt_t'(REPEAT_DELAY);
  // After the first repeat the counter drops back by one period, so it
  // oscillates below REPEAT_DELAY instead of ever wrapping.
  localparam cnt_t C_RPT_RELOAD = cnt_t'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [1:0] sync_q;
  logic       key_up;       // synchronized raw level: 1 = button up
  key_state_e state_q, state_d;
  cnt_t       deb_q, deb_d;
  cnt_t       rpt_q, rpt_d;
  cnt_t       rpt_inc;
  logic       level_d, press_d, release_d, repeat_d;
  logic       level_q, press_q, release_q, repeat_q;

  assign key_up = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      state_q   <= ST_RELEASED;
      deb_q     <= '0;
      rpt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_ni};
      state_q   <= state_d;
      deb_q     <= deb_d;
      rpt_q     <= rpt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    rpt_d     = rpt_q;
    rpt_inc   = rpt_q + cnt_t'(1);
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (!key_up) begin
          state_d = ST_DEB_PRESS;
          deb_d   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (key_up) begin
          state_d = ST_RELEASED;
        end else if (deb_q == C_DEB_LAST) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          rpt_d   = '0;
        end else begin
          deb_d = deb_q + cnt_t'(1);
        end
      end
      ST_PRESSED: begin
        if (key_up) begin
          state_d = ST_DEB_RELEASE;
          deb_d   = '0;
        end
      end
      ST_DEB_RELEASE: begin
        if (!key_up) begin
          state_d = ST_PRESSED;
        end else if (deb_q == C_DEB_LAST) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
      end
    endcase

    // Repeat counting runs only while held; on the releasing edge it halts
    // so a repeat can never share a cycle with the release pulse.
    if ((state_q == ST_PRESSED || state_q == ST_DEB_RELEASE) && !release_d) begin
      if (rpt_inc == C_RPT_DELAY) begin
        repeat_d = repeat_en_i;
        rpt_d    = C_RPT_RELOAD;
      end else begin
        rpt_d = rpt_inc;
      end
    end

    level_d = (state_d == ST_PRESSED) || (state_d == ST_DEB_RELEASE);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule : key_channel
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Debounce, edge detection and auto-repeat for four
//                active-low push buttons; one independent channel per key.
//  Ports       : CLOCK       - system clock (50 MHz)
//                resetn      - asynchronous active-low reset
//                KEY[3:0]    - raw buttons, active-low, bouncing
//                repeat_en   - per-key auto-repeat enable
//                key_level   - debounced level, high while pressed
//                key_press   - one-cycle pulse on accepted press
//                key_release - one-cycle pulse on accepted release
//                key_repeat  - one-cycle auto-repeat pulse while held
//  Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = C_DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = C_DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = C_DEF_REPEAT_PERIOD
) (
  input  logic       CLOCK,
  input  logic       resetn,
  input  logic [3:0] KEY,
  input  logic [3:0] repeat_en,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_repeat
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk_i       (CLOCK),
      .rst_ni      (resetn),
      .key_ni      (KEY[gi]),
      .repeat_en_i (repeat_en[gi]),
      .level_o     (key_level[gi]),
      .press_o     (key_press[gi]),
      .release_o   (key_release[gi]),
      .repeat_o    (key_repeat[gi])
    );
  end

endmodule : key_conditioner
`default_nettype wire

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500_000, meaning the stable-input cycles needed to accept a press or release (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25_000_000, meaning the cycles from key_press to the first key_repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 5_000_000, meaning the cycles between subsequent key_repeat pulses.
REQ-004 The block SHALL have port CLOCK  input  1  meaning the system clock (50 MHz); it is the only clock.
REQ-005 The block SHALL have port resetn  input  1  meaning reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port KEY  input  4  meaning the raw push buttons: asynchronous, active-low, bouncing.
REQ-007 The block SHALL have port repeat_en  input  4  meaning a per-key enable for auto-repeat pulses.
REQ-008 The block SHALL have port key_level  output  4  meaning the debounced state, active-high while pressed.
REQ-009 The block SHALL have port key_press  output  4  meaning a one-cycle pulse on an accepted press.
REQ-010 The block SHALL have port key_release  output  4  meaning a one-cycle pulse on an accepted release.
REQ-011 The block SHALL have port key_repeat  output  4  meaning a one-cycle auto-repeat pulse while held.

Function
REQ-012 Each KEY bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Each key SHALL run an independent FSM with states RELEASED, DEB_PRESS, PRESSED and DEB_RELEASE.
- RELEASED: if the synced value is low, go to DEB_PRESS and clear the debounce counter.
- DEB_PRESS: if the synced value returns high, go back to RELEASED (bounce rejected); otherwise increment the counter; on reaching DEBOUNCE_CYCLES-1, go to PRESSED.
- PRESSED: if the synced value is high, go to DEB_RELEASE and clear the counter.
- DEB_RELEASE: if the synced value returns low, go back to PRESSED; otherwise increment; on reaching DEBOUNCE_CYCLES-1, go to RELEASED.
REQ-014 key_level SHALL be registered, high exactly when the state is PRESSED or DEB_RELEASE.
REQ-015 For a clean press, key_level rise and key_press SHALL occur 2+DEBOUNCE_CYCLES clock edges after the first edge sampling KEY low.
REQ-016 key_release SHALL be a registered pulse asserted on the edge entering RELEASED from DEB_RELEASE.
REQ-017 key_press SHALL be a registered pulse asserted on the edge entering PRESSED from DEB_PRESS; the DEB_RELEASE->PRESSED return SHALL NOT pulse key_press.
REQ-018 The repeat counter SHALL clear on entering PRESSED from DEB_PRESS.
- It increments in PRESSED and DEB_RELEASE.
- The first key_repeat fires when the count reaches REPEAT_DELAY.
- Thereafter key_repeat fires every REPEAT_PERIOD cycles.
- The counter halts, with no pulse, once state is RELEASED.
REQ-019 key_repeat SHALL be gated by repeat_en[i] sampled in the same cycle; deasserting it does not reset the repeat counter.
REQ-020 Counters SHALL be 25 bits wide, unsigned, and SHALL never wrap: after the first repeat, the counter reloads to REPEAT_DELAY-REPEAT_PERIOD.
REQ-021 key_press, key_release and key_repeat SHALL never be asserted in the same cycle for the same key; key_repeat SHALL never coincide with key_press.
REQ-022 Bounce that flips the input within a debounce window SHALL restart that window and produce no pulse.
REQ-023 Keys SHALL be fully independent; simultaneous presses on all four keys SHALL produce four same-cycle key_press pulses.

Reset
REQ-024 On resetn low, and asynchronously, all of the following SHALL be forced:
- synchronizer flops to 1 (released);
- FSMs to RELEASED;
- all counters to 0;
- key_level, key_press, key_release and key_repeat to 0.
REQ-025 A reset asserted mid-debounce or while held SHALL emit no release pulse on exit.
REQ-026 A key still held after reset deasserts SHALL be accepted as a new press after 2+DEBOUNCE_CYCLES cycles.

Structure
REQ-027 The package key_cond_pkg SHALL hold the FSM state encoding, the default parameter values and the counter width (25).
REQ-028 Per-key logic (synchronizer, FSM, counters and pulse registers) SHALL be the sub-module key_channel, instantiated four times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-029 Clean press: KEY[0] held low from edge 0 -> key_press[0] and key_level[0] rise at edge 6, key_press[0] is one cycle wide, and no pulse appears on other keys.
REQ-030 Bounce: KEY[1] low 2 cycles, high 1, then low stable -> exactly one key_press[1], 6 edges after the final falling sample.
REQ-031 Repeat: KEY[2] held 40 cycles with repeat_en=4'b0100 -> key_repeat[2] pulses at 20, 25, 30 and 35 cycles after key_press[2]; none appear with repeat_en=0.
REQ-032 Release: after a held KEY[3] goes high for 4+ cycles -> key_release[3] pulses once 6 edges later and key_level[3] falls in the same cycle; a 2-cycle high glitch gives no release.
REQ-033 Reset mid-hold: resetn pulsed low while KEY[0] is held -> all outputs go to 0 immediately, no key_release is emitted, and a new key_press follows 6 edges after resetn rises.
REQ-034 Simultaneous: KEY=4'b0000 at one edge -> key_press=4'b1111 in one cycle.
